// File: rtl/if_fetch_stage.sv
//============================================================================
// Module : if_fetch_stage
// Brief  : Instruction-fetch stage: PC register, IF/ID capture, halt on PC
//          past end of instruction memory. Optional counters: FETCH_PERF_EN.
// Rev    : 1.0
//============================================================================
`default_nettype none

module if_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          INSTR_NUM = 2048
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  input  logic [31:0] instr_i,
  output logic [63:0] pc_addr_o,
  output logic        ifid_valid_o,
  output logic [63:0] ifid_pc_o,
  output logic [63:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o,
`endif
  output logic        halted_o
);

  localparam logic [63:0] c_pc_limit = 64'(INSTR_NUM) * 64'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic [63:0] r_ifid_pc, w_ifid_pc_nxt;
  logic [63:0] r_ifid_pc4, w_ifid_pc4_nxt;
  logic [31:0] r_ifid_instr, w_ifid_instr_nxt;

  logic [63:0] w_redirect_pc;
  logic        w_pc_oor;
  logic        w_redirect_oor;

  assign w_redirect_pc  = {redirect_pc_i[63:2], 2'b00};
  assign w_pc_oor       = (r_pc >= c_pc_limit);
  assign w_redirect_oor = (w_redirect_pc >= c_pc_limit);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_ifid_instr_nxt = r_ifid_instr;
    case (r_state)
      ST_BOOT: begin
        w_ifid_valid_nxt = 1'b0;
        w_state_nxt      = ST_RUN;
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
        end
      end
      ST_RUN: begin
        if (redirect_i) begin
          w_pc_nxt         = w_redirect_pc;
          w_ifid_valid_nxt = 1'b0;
        end else if (w_pc_oor) begin
          w_ifid_valid_nxt = 1'b0;
          w_state_nxt      = ST_HALT;
        end else if (stall_i) begin
          if (flush_i) begin
            w_ifid_valid_nxt = 1'b0;
          end
        end else begin
          w_ifid_pc_nxt    = r_pc;
          w_ifid_pc4_nxt   = r_pc + 64'd4;
          w_ifid_instr_nxt = instr_i;
          w_ifid_valid_nxt = !flush_i;
          w_pc_nxt         = r_pc + 64'd4;
        end
      end
      ST_HALT: begin
        // Stall and flush are meaningless once fetch has stopped.
        w_ifid_valid_nxt = 1'b0;
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
          if (!w_redirect_oor) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        w_state_nxt      = ST_BOOT;
        w_ifid_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 64'd0;
      r_ifid_pc4   <= 64'd0;
      r_ifid_instr <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
    end
  end

  assign pc_addr_o    = r_pc;
  assign ifid_valid_o = r_ifid_valid;
  assign ifid_pc_o    = r_ifid_pc;
  assign ifid_pc4_o   = r_ifid_pc4;
  assign ifid_instr_o = r_ifid_instr;
  assign halted_o     = (r_state == ST_HALT);

`ifdef FETCH_PERF_EN
  logic        w_run_live;
  logic        w_fetch_inc, w_stall_inc, w_kill_inc;
  logic [31:0] r_perf_fetch, r_perf_stall, r_perf_flush;

  // Cycles that reach the stall/normal branches of RUN.
  assign w_run_live  = (r_state == ST_RUN) && !redirect_i && !w_pc_oor;
  assign w_fetch_inc = w_run_live && !stall_i && !flush_i;
  assign w_stall_inc = w_run_live && stall_i;
  assign w_kill_inc  = ((r_state == ST_RUN) && redirect_i) || (w_run_live && flush_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_fetch <= 32'd0;
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (w_fetch_inc && (r_perf_fetch != 32'hFFFF_FFFF)) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_stall_inc && (r_perf_stall != 32'hFFFF_FFFF)) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_kill_inc  && (r_perf_flush != 32'hFFFF_FFFF)) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule

`default_nettype wire
